// File: rtl/seq_pattern_detector.sv
// ---------------------------------------------------------------------------
// seq_pattern_detector
//
// Serial bit-stream pattern detector. The pattern value and length can be
// changed at runtime, up to MAX_LEN bits. OVERLAP selects whether matches may
// share bits. Matches are counted in a counter that stops at all ones.
//
// Ports
//   clk        in   1         clock, rising edge
//   rst        in   1         asynchronous reset, active-low
//   in_valid   in   1         sample 'in' on this edge
//   in         in   1         serial data bit
//   clr        in   1         synchronous clear of history, fill count, match_cnt
//   cfg_we     in   1         load cfg_pat / cfg_len on this edge
//   cfg_pat    in   MAX_LEN   pattern, LSB-aligned; bit [len-1] is received first
//   cfg_len    in   LW        pattern length (legal range 1..MAX_LEN)
//   out        out  1         registered one-cycle match pulse
//   match_cnt  out  CNT_W     saturating match count
//   cnt_sat    out  1         match_cnt is all ones
//   cfg_err    out  1         one-cycle pulse: cfg_we with an illegal cfg_len
// ---------------------------------------------------------------------------
module seq_pattern_detector #(
  parameter int                 MAX_LEN     = 8,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = 'h05,
  parameter int                 RST_LEN     = 3,
  parameter bit                 OVERLAP     = 1'b1,
  parameter int                 CNT_W       = 16,
  localparam int                LW          = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in,
  input  logic               clr,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LW-1:0]      cfg_len,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] hist_reg, hist_next;
  logic [LW-1:0]      fill_reg, fill_next;
  logic [MAX_LEN-1:0] pat_reg,  pat_next;
  logic [LW-1:0]      len_reg,  len_next;
  logic               out_reg,  out_next;
  logic [CNT_W-1:0]   cnt_reg,  cnt_next;
  logic               err_reg,  err_next;

  logic [MAX_LEN-1:0] shifted;
  logic [MAX_LEN-1:0] len_mask;
  logic [LW:0]        fill_inc;
  logic               match;
  logic               cfg_legal;

  // History as it would look with the current bit appended; the newest bit
  // sits in bit 0, so the first pattern bit lines up with bit [len-1].
  assign shifted = {hist_reg[MAX_LEN-2:0], in};

  // Only the low len bits take part in the compare.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign len_mask[gi] = (int'(len_reg) > gi);
    end
  endgenerate

  // One extra bit so fill+1 cannot wrap before the compare against len.
  assign fill_inc  = {1'b0, fill_reg} + {{LW{1'b0}}, 1'b1};

  assign match     = in_valid
                   && (fill_inc >= {1'b0, len_reg})
                   && (((shifted ^ pat_reg) & len_mask) == '0);

  assign cfg_legal = (cfg_len != '0) && (cfg_len <= LW'(MAX_LEN));

  always_comb begin
    hist_next = hist_reg;
    fill_next = fill_reg;
    pat_next  = pat_reg;
    len_next  = len_reg;
    out_next  = 1'b0;
    cnt_next  = cnt_reg;
    err_next  = 1'b0;

    if (clr) begin
      // Clear wins over everything; configuration and input are ignored.
      hist_next = '0;
      fill_next = '0;
      cnt_next  = '0;
    end else if (cfg_we && cfg_legal) begin
      // New pattern: old history no longer means anything, and the data
      // bit on this edge is dropped.
      pat_next  = cfg_pat;
      len_next  = cfg_len;
      hist_next = '0;
      fill_next = '0;
    end else begin
      // A rejected configuration only raises the error pulse; data flows on.
      err_next = cfg_we;
      if (in_valid) begin
        hist_next = shifted;
        fill_next = (fill_reg >= len_reg) ? len_reg : fill_inc[LW-1:0];
        if (match) begin
          out_next = 1'b1;
          if (cnt_reg != '1) begin
            cnt_next = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          // Without overlap the next match must be built from fresh bits.
          if (!OVERLAP) begin
            fill_next = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_reg <= '0;
      fill_reg <= '0;
      pat_reg  <= RST_PATTERN;
      len_reg  <= LW'(RST_LEN);
      out_reg  <= 1'b0;
      cnt_reg  <= '0;
      err_reg  <= 1'b0;
    end else begin
      hist_reg <= hist_next;
      fill_reg <= fill_next;
      pat_reg  <= pat_next;
      len_reg  <= len_next;
      out_reg  <= out_next;
      cnt_reg  <= cnt_next;
      err_reg  <= err_next;
    end
  end

  assign out       = out_reg;
  assign match_cnt = cnt_reg;
  assign cnt_sat   = (cnt_reg == '1);
  assign cfg_err   = err_reg;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_detector
//
// Three detector builds share one stimulus stream:
//   u_ovl  : defaults (overlapping matches)
//   u_novl : OVERLAP=0
//   u_c2   : CNT_W=2 (early counter saturation)
// A reference model keeps the received bits as an integer plus a count of bits
// since the last flush. A match means the low len bits of that integer equal
// the low len bits of the pattern.
// ---------------------------------------------------------------------------
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in = 1'b0;
  logic       clr = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pat = 8'h00;
  logic [3:0] cfg_len = 4'd0;

  logic        out_a, sat_a, err_a;
  logic [15:0] cnt_a;
  logic        out_b, sat_b, err_b;
  logic [15:0] cnt_b;
  logic        out_c, sat_c, err_c;
  logic [1:0]  cnt_c;

  always #5 clk = ~clk;

  seq_pattern_detector u_ovl (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .clr(clr),
    .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .out(out_a), .match_cnt(cnt_a), .cnt_sat(sat_a), .cfg_err(err_a)
  );

  seq_pattern_detector #(.OVERLAP(1'b0)) u_novl (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .clr(clr),
    .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .out(out_b), .match_cnt(cnt_b), .cnt_sat(sat_b), .cfg_err(err_b)
  );

  seq_pattern_detector #(.CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in), .clr(clr),
    .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .out(out_c), .match_cnt(cnt_c), .cnt_sat(sat_c), .cfg_err(err_c)
  );

  // ---------------- reference model ----------------
  longint unsigned mh[3];           // received bits, newest in bit 0
  int              mn[3];           // bits received since last flush
  int              mc[3];           // match count
  bit              eo[3];           // expected out
  bit              ee;              // expected cfg_err (same for all)
  int              mpat, mlen;
  int              ovl[3]  = '{1, 0, 1};
  int              cmax[3] = '{65535, 65535, 3};

  int    n_chk  = 0;
  int    n_pass = 0;
  string phase  = "reset";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mh[i] = 0; mn[i] = 0; mc[i] = 0; eo[i] = 1'b0;
    end
    ee = 1'b0; mpat = 5; mlen = 3;
  endtask

  // Predict the state after the coming clock edge from the current inputs.
  task automatic model_edge();
    longint unsigned v, msk;
    bit hit;
    ee = 1'b0;
    for (int i = 0; i < 3; i++) eo[i] = 1'b0;
    if (clr) begin
      for (int i = 0; i < 3; i++) begin mh[i] = 0; mn[i] = 0; mc[i] = 0; end
    end else if (cfg_we && cfg_len >= 1 && cfg_len <= 8) begin
      mpat = int'(cfg_pat); mlen = int'(cfg_len);
      for (int i = 0; i < 3; i++) begin mh[i] = 0; mn[i] = 0; end
    end else begin
      ee = cfg_we;
      if (in_valid) begin
        msk = (64'd1 << mlen) - 1;
        for (int i = 0; i < 3; i++) begin
          v   = (mh[i] << 1) | longint'(in);
          hit = (mn[i] + 1 >= mlen) && ((v & msk) == (longint'(mpat) & msk));
          eo[i] = hit;
          mh[i] = v & 64'hFFFF_FFFF;
          mn[i] = mn[i] + 1;
          if (hit) begin
            if (mc[i] < cmax[i]) mc[i]++;
            if (ovl[i] == 0) begin mn[i] = 0; mh[i] = 0; end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk({phase, " ovl.out"},  32'(out_a), 32'(eo[0]));
    chk({phase, " ovl.cnt"},  32'(cnt_a), mc[0]);
    chk({phase, " ovl.sat"},  32'(sat_a), 32'(mc[0] == cmax[0]));
    chk({phase, " ovl.err"},  32'(err_a), 32'(ee));
    chk({phase, " novl.out"}, 32'(out_b), 32'(eo[1]));
    chk({phase, " novl.cnt"}, 32'(cnt_b), mc[1]);
    chk({phase, " novl.sat"}, 32'(sat_b), 32'(mc[1] == cmax[1]));
    chk({phase, " novl.err"}, 32'(err_b), 32'(ee));
    chk({phase, " c2.out"},   32'(out_c), 32'(eo[2]));
    chk({phase, " c2.cnt"},   32'(cnt_c), mc[2]);
    chk({phase, " c2.sat"},   32'(sat_c), 32'(mc[2] == cmax[2]));
    chk({phase, " c2.err"},   32'(err_c), 32'(ee));
  endtask

  // One clock: drive at the falling edge, check 1 time unit after the rising edge.
  task automatic step(input bit v, input bit b, input bit c, input bit we,
                      input logic [7:0] p, input logic [3:0] l);
    @(negedge clk);
    in_valid = v; in = b; clr = c; cfg_we = we; cfg_pat = p; cfg_len = l;
    model_edge();
    @(posedge clk);
    #1;
    $display("%s: v=%0b in=%0b clr=%0b we=%0b len=%0d -> out=%0b%0b%0b cnt=%0d/%0d/%0d err=%0b",
             phase, v, b, c, we, l, out_a, out_b, out_c, cnt_a, cnt_b, cnt_c, err_a);
    check_all();
  endtask

  task automatic bit_in(input bit b);
    step(1'b1, b, 1'b0, 1'b0, 8'h00, 4'd0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0);
  endtask

  task automatic do_clr();
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0);
  endtask

  initial begin
    logic [7:0] stream;
    model_reset();
    #3;
    check_all();
    #9 rst = 1'b1;

    // 1/2: "10101" with the reset pattern "101"
    phase = "t1";
    bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1);
    chk("t1 ovl two matches", 32'(cnt_a), 32'd2);
    chk("t2 novl one match",  32'(cnt_b), 32'd1);

    // 3: 8-bit pattern B4, input with gaps, cfg bit itself discarded
    phase = "t3";
    do_clr();
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'hB4, 4'd8);
    stream = 8'hB4;
    for (int i = 7; i >= 0; i--) begin
      bit_in(stream[i]);
      if (i % 3 == 0) idle();
    end
    chk("t3 one long match", 32'(cnt_a), 32'd1);

    // 4: clr collides with the completing bit
    phase = "t4";
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 4'd3);
    bit_in(1); bit_in(0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 4'd0);
    chk("t4 clr kills pulse", 32'(out_a), 32'd0);
    bit_in(1); bit_in(0); bit_in(1);
    chk("t4 match after clr", 32'(cnt_a), 32'd1);

    // 5: five matches saturate the 2-bit counter
    phase = "t5";
    do_clr();
    for (int k = 0; k < 5; k++) begin bit_in(1); bit_in(0); bit_in(1); end
    chk("t5 c2 cnt held", 32'(cnt_c), 32'd3);
    chk("t5 c2 sat",      32'(sat_c), 32'd1);
    chk("t5 ovl cnt",     32'(cnt_a), 32'd5);

    // 6: illegal lengths, then async reset in mid-pattern
    phase = "t6";
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 4'd0);
    chk("t6 err len0", 32'(err_a), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 4'd9);
    chk("t6 err len9", 32'(err_a), 32'd1);
    bit_in(1);
    chk("t6 101 still matches", 32'(out_a), 32'd1);
    bit_in(1); bit_in(0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1 model_reset();
    phase = "arst";
    check_all();
    chk("arst cnt zero", 32'(cnt_a), 32'd0);
    @(negedge clk) rst = 1'b1;
    bit_in(1);
    chk("arst no match", 32'(out_a), 32'd0);

    // randomized traffic
    phase = "rand";
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] l;
      logic [7:0] p;
      l = 4'($urandom_range(0, 10));
      if ($urandom_range(0, 3) != 0 && l > 4) l = 4'($urandom_range(1, 4));
      p = 8'($urandom);
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 63) == 0,
           $urandom_range(0, 39) == 0, p, l);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
